data_memory: RTL and testbench
==============================

Name: data_memory

Overview:
- Word-addressed data memory; the responder end of the CPU data-memory port (a / we / wd / rd).
- Serves the single-cycle core: combinational read, write on the clock edge.
- After reset, a hardware clear sequencer zeroes every word before the memory accepts traffic; `busy` reports this.
- Misaligned or blocked write attempts are flagged and never corrupt storage.

Parameters:
- DEPTH, 256, number of 32-bit words; must be a power of two and ≥ 2.
- ADDR_W, log2(DEPTH) (8), word-index width; derived, not overridden independently.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- a  in  32  byte address from the CPU (alu result).
- we  in  1  write enable.
- wd  in  32  write data.
- rd  out  32  read data (combinational).
- busy  out  1  1 while the clear sequence runs; CPU traffic is ignored.
- misaligned  out  1  combinational: a[1:0] != 0 while not busy.
- err  out  1  sticky error: a write was attempted while busy, or to a misaligned address.

Behaviour:
- Clock and reset:
  - One clock.
  - Reset is synchronous and active-high.
- Address decode:
  - idx = a[ADDR_W+1:2].
  - Bits a[31:ADDR_W+2] are ignored, so addresses wrap modulo DEPTH*4.
- Reset:
  - Any posedge with reset=1 sets state=CLEAR, clr_idx=0, err=0.
  - No memory word is written while reset is held.
  - After that edge: busy=1, rd=0, misaligned=0, err=0.
- States:
  - CLEAR:
    - Each posedge with reset=0 writes mem[clr_idx]=0, then clr_idx++.
    - On the edge that writes index DEPTH-1, state goes to READY.
    - busy is therefore 1 for exactly DEPTH posedges after reset deasserts and is 0 after the DEPTH-th edge.
  - READY:
    - Normal operation.
    - No transition except via reset.
- Reset mid-clear restarts the sequence at clr_idx=0.
  - Words already cleared stay 0.
  - The full DEPTH-edge sweep repeats.
- Read, READY:
  - rd = mem[idx], combinational, no latency.
  - The low two address bits are ignored for reads, so misaligned reads return the containing word.
- Read, CLEAR: rd=0 regardless of a.
- Write, READY:
  - On a posedge with we=1 and a[1:0]==0: mem[idx] <= wd.
  - rd for the same address shows the old value before the edge and wd after it; there is no bypass.
- Misaligned write (READY, we=1, a[1:0]!=0):
  - No memory change.
  - err <= 1 at that edge.
- Write during CLEAR (we=1, reset=0): ignored, err <= 1.
- err is sticky; only reset clears it.
- we=0 never changes memory or err.
- Uninitialised contents are never visible: every rd path after reset returns either 0 or a value written after the clear completed.

Test Plan:
Run with DEPTH=16 unless stated.
1. Reset clear:
   - Stimulus: reset high 2 cycles, then low; sample busy each edge.
   - Required: busy=1 for exactly 16 edges, 0 from edge 17 on; rd=0 for a=0x00..0x3C afterwards.
2. Write/read:
   - Stimulus: after clear, write wd=0xDEADBEEF at a=0x8; write 0x12345678 at a=0x3C.
   - Required: rd(0x8)=0xDEADBEEF, rd(0x3C)=0x12345678, rd(0x4)=0; rd(0x8) reads 0 before the write edge and 0xDEADBEEF after it, in the same cycle window.
3. Wrap-around:
   - Stimulus: write 0xA5A5A5A5 at a=0x40.
   - Required: rd(0x0)=0xA5A5A5A5, since 0x40 wraps to idx 0.
4. Misaligned:
   - Stimulus: with mem[1]=0x11111111, write 0xFFFFFFFF at a=0x6.
   - Required: misaligned=1 during the cycle, mem[1] unchanged (rd(0x4)=0x11111111), err=1 and stays 1 across 5 idle cycles; rd(0x6)=0x11111111.
5. Write while busy:
   - Stimulus: assert we=1, a=0x10, wd=0x55 on the 3rd clear edge.
   - Required: after clear, rd(0x10)=0, err=1.
6. Reset mid-clear:
   - Stimulus: pulse reset for 1 cycle after 8 clear edges, following a prior fill of all words with 0xFFFFFFFF before the first reset.
   - Required: busy=1 for a fresh 16 edges after the pulse, all words read 0, err=0.

Source files
------------

// File: rtl/data_memory_if.sv
// Data-memory port between the CPU (master) and data_memory (slave).
//   a          byte address from the CPU
//   we         write enable
//   wd         write data
//   rd         read data, combinational
//   busy       post-reset clear sweep in progress; CPU traffic ignored
//   misaligned a[1:0] != 0 while not busy
//   err        sticky: write while busy or to a misaligned address
interface data_memory_if;
   logic [31:0] a;
   logic        we;
   logic [31:0] wd;
   logic [31:0] rd;
   logic        busy;
   logic        misaligned;
   logic        err;

   modport master (
      output a, we, wd,
      input  rd, busy, misaligned, err
   );

   modport slave (
      input  a, we, wd,
      output rd, busy, misaligned, err
   );
endinterface

// File: rtl/data_memory.sv
// Word-addressed data memory for the single-cycle core: combinational read,
// write on posedge. After reset a sweep zeroes every word before traffic is
// accepted, so uninitialised contents are never visible.
//   clk    system clock
//   reset  synchronous, active-high
//   bus    data_memory_if.slave (a, we, wd -> rd, busy, misaligned, err)
module data_memory #(
   parameter int unsigned DEPTH  = 256,
   localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   data_memory_if.slave  bus
);

   typedef enum logic {StClear, StReady} state_e;

   localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(DEPTH - 1);

   state_e              state_q;
   logic [ADDR_W-1:0]   clr_idx_q;
   logic                err_q;
   logic [31:0]         mem_q [DEPTH];

   logic [ADDR_W-1:0]   idx;
   logic                aligned;
   logic                busy;
   logic                mem_we;
   logic [ADDR_W-1:0]   mem_widx;
   logic [31:0]         mem_wdata;
   logic                unused_a;

   // Upper address bits are dropped so addresses wrap modulo DEPTH*4.
   assign idx      = bus.a[ADDR_W+1:2];
   assign aligned  = (bus.a[1:0] == 2'b00);
   assign busy     = (state_q == StClear);
   assign unused_a = ^bus.a[31:ADDR_W+2];

   // Single write port shared by the clear sweep and CPU stores.
   always_comb begin
      mem_we    = 1'b0;
      mem_widx  = idx;
      mem_wdata = bus.wd;
      if (!reset) begin
         if (busy) begin
            mem_we    = 1'b1;
            mem_widx  = clr_idx_q;
            mem_wdata = '0;
         end else begin
            mem_we    = bus.we && aligned;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[mem_widx] <= mem_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StClear;
         clr_idx_q <= '0;
         err_q     <= 1'b0;
      end else begin
         unique case (state_q)
            StClear: begin
               if (bus.we) begin
                  err_q <= 1'b1;
               end
               clr_idx_q <= clr_idx_q + ADDR_W'(1);
               if (clr_idx_q == LastIdx) begin
                  state_q <= StReady;
               end
            end
            StReady: begin
               if (bus.we && !aligned) begin
                  err_q <= 1'b1;
               end
            end
         endcase
      end
   end

   assign bus.rd         = busy ? 32'h0 : mem_q[idx];
   assign bus.busy       = busy;
   assign bus.misaligned = !busy && !aligned;
   assign bus.err        = err_q;

endmodule

// File: tb/tb_data_memory.sv
module tb_data_memory;

   localparam int unsigned DEPTH = 16;

   logic clk = 1'b0;
   logic reset;
   int   errors = 0;
   int   checks = 0;

   data_memory_if bus ();

   data_memory #(.DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      bus.a  = 32'h2;
      bus.we = 1'b0;
      bus.wd = 32'h0;
      reset  = 1'b1;
      tick();
      tick();
      checks++;
      if (bus.busy !== 1'b1) begin
         errors++; $display("FAIL reset_busy got=%b exp=1", bus.busy);
      end
      checks++;
      if (bus.rd !== 32'h0) begin
         errors++; $display("FAIL reset_rd got=%h exp=0", bus.rd);
      end
      checks++;
      if (bus.misaligned !== 1'b0) begin
         errors++; $display("FAIL reset_misaligned got=%b exp=0", bus.misaligned);
      end
      checks++;
      if (bus.err !== 1'b0) begin
         errors++; $display("FAIL reset_err got=%b exp=0", bus.err);
      end
      reset = 1'b0;
      for (int e = 1; e <= 20; e++) begin
         tick();
         checks++;
         if (bus.busy !== ((e < DEPTH) ? 1'b1 : 1'b0)) begin
            errors++;
            $display("FAIL clear_busy edge=%0d got=%b exp=%b", e, bus.busy, (e < DEPTH));
         end
      end
      for (int i = 0; i < DEPTH; i++) begin
         bus.a = 32'(i * 4);
         #1;
         checks++;
         if (bus.rd !== 32'h0) begin
            errors++; $display("FAIL clear_rd a=%h got=%h exp=0", bus.a, bus.rd);
         end
      end
   endtask

   task automatic test_write_read();
      bus.a  = 32'h8;
      bus.we = 1'b1;
      bus.wd = 32'hDEADBEEF;
      #1;
      checks++;
      if (bus.rd !== 32'h0) begin
         errors++; $display("FAIL wr_before_edge got=%h exp=0", bus.rd);
      end
      tick();
      checks++;
      if (bus.rd !== 32'hDEADBEEF) begin
         errors++; $display("FAIL wr_after_edge got=%h exp=deadbeef", bus.rd);
      end
      // Back-to-back store to a different word.
      bus.a  = 32'h3C;
      bus.wd = 32'h12345678;
      tick();
      bus.we = 1'b0;
      #1;
      checks++;
      if (bus.rd !== 32'h12345678) begin
         errors++; $display("FAIL rd_3c got=%h exp=12345678", bus.rd);
      end
      bus.a = 32'h8;
      #1;
      checks++;
      if (bus.rd !== 32'hDEADBEEF) begin
         errors++; $display("FAIL rd_8 got=%h exp=deadbeef", bus.rd);
      end
      bus.a = 32'h4;
      #1;
      checks++;
      if (bus.rd !== 32'h0) begin
         errors++; $display("FAIL rd_4 got=%h exp=0", bus.rd);
      end
   endtask

   task automatic test_wrap();
      bus.a  = 32'h40;
      bus.we = 1'b1;
      bus.wd = 32'hA5A5A5A5;
      tick();
      bus.we = 1'b0;
      bus.a  = 32'h0;
      #1;
      checks++;
      if (bus.rd !== 32'hA5A5A5A5) begin
         errors++; $display("FAIL wrap_rd0 got=%h exp=a5a5a5a5", bus.rd);
      end
   endtask

   task automatic test_misaligned();
      bus.a  = 32'h4;
      bus.we = 1'b1;
      bus.wd = 32'h11111111;
      tick();
      checks++;
      if (bus.err !== 1'b0) begin
         errors++; $display("FAIL err_before_mis got=%b exp=0", bus.err);
      end
      bus.a  = 32'h6;
      bus.wd = 32'hFFFFFFFF;
      #1;
      checks++;
      if (bus.misaligned !== 1'b1) begin
         errors++; $display("FAIL mis_flag got=%b exp=1", bus.misaligned);
      end
      tick();
      bus.we = 1'b0;
      checks++;
      if (bus.err !== 1'b1) begin
         errors++; $display("FAIL mis_err got=%b exp=1", bus.err);
      end
      checks++;
      if (bus.rd !== 32'h11111111) begin
         errors++; $display("FAIL mis_rd6 got=%h exp=11111111", bus.rd);
      end
      bus.a = 32'h4;
      #1;
      checks++;
      if (bus.rd !== 32'h11111111) begin
         errors++; $display("FAIL mis_rd4 got=%h exp=11111111", bus.rd);
      end
      checks++;
      if (bus.misaligned !== 1'b0) begin
         errors++; $display("FAIL aligned_flag got=%b exp=0", bus.misaligned);
      end
      for (int c = 0; c < 5; c++) begin
         tick();
         checks++;
         if (bus.err !== 1'b1) begin
            errors++; $display("FAIL err_sticky cyc=%0d got=%b exp=1", c, bus.err);
         end
      end
   endtask

   task automatic test_write_while_busy();
      int n;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      tick();
      // Third clear edge: store to a not-yet-cleared word; fourth: to word 0,
      // which the sweep has already passed.
      bus.a  = 32'h10;
      bus.wd = 32'h55;
      bus.we = 1'b1;
      tick();
      bus.a  = 32'h0;
      tick();
      bus.we = 1'b0;
      n = 4;
      while (bus.busy === 1'b1 && n < 40) begin
         tick();
         n++;
      end
      checks++;
      if (n != DEPTH) begin
         errors++; $display("FAIL busy_clear_len got=%0d exp=%0d", n, DEPTH);
      end
      bus.a = 32'h10;
      #1;
      checks++;
      if (bus.rd !== 32'h0) begin
         errors++; $display("FAIL busy_wr_rd10 got=%h exp=0", bus.rd);
      end
      bus.a = 32'h0;
      #1;
      checks++;
      if (bus.rd !== 32'h0) begin
         errors++; $display("FAIL busy_wr_rd0 got=%h exp=0", bus.rd);
      end
      checks++;
      if (bus.err !== 1'b1) begin
         errors++; $display("FAIL busy_wr_err got=%b exp=1", bus.err);
      end
   endtask

   task automatic test_reset_mid_clear();
      int n;
      bus.we = 1'b1;
      bus.wd = 32'hFFFFFFFF;
      for (int i = 0; i < DEPTH; i++) begin
         bus.a = 32'(i * 4);
         tick();
      end
      bus.we = 1'b0;
      bus.a  = 32'h14;
      #1;
      checks++;
      if (bus.rd !== 32'hFFFFFFFF) begin
         errors++; $display("FAIL fill_rd got=%h exp=ffffffff", bus.rd);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int e = 0; e < 8; e++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if (bus.busy !== 1'b1) begin
         errors++; $display("FAIL midrst_busy got=%b exp=1", bus.busy);
      end
      n = 0;
      while (bus.busy === 1'b1 && n < 40) begin
         tick();
         n++;
      end
      checks++;
      if (n != DEPTH) begin
         errors++; $display("FAIL midrst_clear_len got=%0d exp=%0d", n, DEPTH);
      end
      checks++;
      if (bus.err !== 1'b0) begin
         errors++; $display("FAIL midrst_err got=%b exp=0", bus.err);
      end
      for (int i = 0; i < DEPTH; i++) begin
         bus.a = 32'(i * 4);
         #1;
         checks++;
         if (bus.rd !== 32'h0) begin
            errors++; $display("FAIL midrst_rd a=%h got=%h exp=0", bus.a, bus.rd);
         end
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_wrap();
      test_misaligned();
      test_write_while_busy();
      test_reset_mid_clear();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
